// File: rtl/axi_lite_gpio_sequencer.sv
// rtl/axi_lite_gpio_sequencer.sv - AXI4-Lite write master that programs a GPIO direction
// register, then plays a list of data-register writes at a programmable interval.
module axi_lite_gpio_sequencer #(
  parameter int         ADDR_WIDTH = 4,
  parameter logic [3:0] DATA_ADDR  = 4'h0,
  parameter logic [3:0] DIR_ADDR   = 4'h4,
  parameter int         DEPTH      = 8,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            dir_mask,
  input  logic [32*DEPTH-1:0]    pattern,
  input  logic [4:0]             num_steps,
  input  logic [CNT_WIDTH-1:0]   interval,
  input  logic                   loop_en,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [3:0]             step_idx,
  output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
  output logic [2:0]             m_axi_awprot,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [31:0]            m_axi_wdata,
  output logic [3:0]             m_axi_wstrb,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DIR, S_WR_DATA, S_RESP, S_DELAY, S_NEXT, S_FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] DATA_A = ADDR_WIDTH'(DATA_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DIR_A  = ADDR_WIDTH'(DIR_ADDR);
  localparam logic [4:0]            DEPTH5 = 5'(DEPTH);

  state_t                 state, state_d;
  logic [31:0]            dir_q;
  logic [32*DEPTH-1:0]    pattern_q;
  logic [4:0]             num_q;
  logic [CNT_WIDTH-1:0]   interval_q, cnt;
  logic                   loop_q, issued, aw_done, w_done, is_dir, abort_pend;
  logic                   aw_fire, w_fire, xfer_done, abort_any, last_step;
  logic [4:0]             num_clamped;
  logic [31:0]            cur_entry;

  assign m_axi_awprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

  assign num_clamped = (num_steps > DEPTH5) ? DEPTH5 : num_steps;
  assign aw_fire     = m_axi_awvalid & m_axi_awready;
  assign w_fire      = m_axi_wvalid & m_axi_wready;
  // Address and data channels complete independently; either may finish first.
  assign xfer_done   = issued & (aw_done | aw_fire) & (w_done | w_fire);
  assign abort_any   = abort | abort_pend;
  assign last_step   = ({1'b0, step_idx} + 5'd1) == num_q;

  always_comb begin
    cur_entry = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (step_idx == 4'(k)) cur_entry = pattern_q[32*k +: 32];
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:              if (start) state_d = S_WR_DIR;
      S_WR_DIR, S_WR_DATA: if (xfer_done) state_d = S_RESP;
      S_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00 || abort_any) state_d = S_FINISH;
          else if (is_dir)                       state_d = (num_q == 5'd0) ? S_FINISH : S_WR_DATA;
          else                                   state_d = (interval_q == '0) ? S_NEXT : S_DELAY;
        end
      end
      S_DELAY: begin
        if (abort)           state_d = S_FINISH;
        else if (cnt == '0)  state_d = S_NEXT;
      end
      S_NEXT: begin
        if (abort_any || (last_step && !loop_q)) state_d = S_FINISH;
        else                                     state_d = S_WR_DATA;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      step_idx      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      dir_q         <= '0;
      pattern_q     <= '0;
      num_q         <= '0;
      interval_q    <= '0;
      loop_q        <= 1'b0;
      cnt           <= '0;
      issued        <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      is_dir        <= 1'b0;
      abort_pend    <= 1'b0;
    end else begin
      state        <= state_d;
      busy         <= (state_d != S_IDLE) && (state_d != S_FINISH);
      done         <= (state_d == S_FINISH);
      m_axi_bready <= (state_d == S_RESP);
      if (aw_fire) begin
        m_axi_awvalid <= 1'b0;
        aw_done       <= 1'b0 | 1'b1;
      end
      if (w_fire) begin
        m_axi_wvalid <= 1'b0;
        w_done       <= 1'b1;
      end
      if (state == S_IDLE) abort_pend <= 1'b0;
      else if (abort && (state == S_WR_DIR || state == S_WR_DATA || state == S_RESP))
        abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            dir_q      <= dir_mask;
            pattern_q  <= pattern;
            num_q      <= num_clamped;
            interval_q <= interval;
            loop_q     <= loop_en;
            error      <= 1'b0;
            step_idx   <= '0;
            is_dir     <= 1'b1;
          end
        end
        S_WR_DIR, S_WR_DATA: begin
          // Both valids rise together on the cycle after entering the write state.
          if (!issued) begin
            issued        <= 1'b1;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awaddr  <= (state == S_WR_DIR) ? DIR_A : DATA_A;
            m_axi_wdata   <= (state == S_WR_DIR) ? dir_q : cur_entry;
          end
        end
        S_RESP: begin
          issued <= 1'b0;
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) error <= 1'b1;
            is_dir <= 1'b0;
            cnt    <= interval_q - CNT_WIDTH'(1);
          end
        end
        S_DELAY: cnt <= cnt - CNT_WIDTH'(1);
        S_NEXT: begin
          if (state_d == S_WR_DATA) step_idx <= last_step ? 4'd0 : step_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_gpio_sequencer.sv
// tb/tb_axi_lite_gpio_sequencer.sv - self-checking bench for axi_lite_gpio_sequencer
// with a small GPIO slave model and a write scoreboard.
module tb_axi_lite_gpio_sequencer;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int AW    = 4;

  logic                aclk = 1'b0;
  logic                areset, start, abort, loop_en;
  logic [31:0]         dir_mask;
  logic [32*DEPTH-1:0] pattern;
  logic [4:0]          num_steps;
  logic [CW-1:0]       interval;
  logic                busy, done, error;
  logic [3:0]          step_idx;
  logic [AW-1:0]       m_axi_awaddr;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid, m_axi_awready;
  logic [31:0]         m_axi_wdata;
  logic [3:0]          m_axi_wstrb;
  logic                m_axi_wvalid, m_axi_wready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid, m_axi_bready;

  always #5 aclk = ~aclk;

  axi_lite_gpio_sequencer #(
    .ADDR_WIDTH(AW), .DATA_ADDR(4'h0), .DIR_ADDR(4'h4), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort),
    .dir_mask(dir_mask), .pattern(pattern), .num_steps(num_steps),
    .interval(interval), .loop_en(loop_en),
    .busy(busy), .done(done), .error(error), .step_idx(step_idx),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  // GPIO slave model: always-ready address channel, optionally delayed wready.
  logic        wdly_req = 1'b0, err_req = 1'b0;
  logic        aw_got, w_got, w_ok;
  logic [3:0]  aw_a, a_n, data_cnt;
  logic [31:0] w_d, d_n, gpio_out, gpio_dir;
  logic [2:0]  wcnt;
  logic        s_aw_fire, s_w_fire, ag_n, wg_n, pair;

  assign m_axi_awready = 1'b1;
  assign m_axi_wready  = wdly_req ? w_ok : 1'b1;

  always_comb begin
    s_aw_fire = m_axi_awvalid & m_axi_awready;
    s_w_fire  = m_axi_wvalid & m_axi_wready;
    ag_n      = aw_got | s_aw_fire;
    wg_n      = w_got | s_w_fire;
    a_n       = s_aw_fire ? m_axi_awaddr : aw_a;
    d_n       = s_w_fire ? m_axi_wdata : w_d;
    pair      = ag_n & wg_n & ~m_axi_bvalid;
  end

  always @(posedge aclk) begin
    if (areset) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_ok <= 1'b0; wcnt <= '0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00; data_cnt <= '0;
      gpio_out <= '0; gpio_dir <= '0;
    end else begin
      if (s_aw_fire) wcnt <= 3'd3;
      else if (wcnt != 3'd0) wcnt <= wcnt - 3'd1;
      if (wcnt == 3'd1) w_ok <= 1'b1;
      else if (s_w_fire) w_ok <= 1'b0;
      if (pair) begin
        aw_got <= 1'b0; w_got <= 1'b0; m_axi_bvalid <= 1'b1;
        m_axi_bresp <= (err_req && a_n == 4'h0 && data_cnt == 4'd0) ? 2'b10 : 2'b00;
        if (a_n == 4'h4) begin gpio_dir <= d_n; data_cnt <= '0; end
        else begin gpio_out <= d_n; data_cnt <= data_cnt + 4'd1; end
      end else begin
        aw_got <= ag_n; w_got <= wg_n; aw_a <= a_n; w_d <= d_n;
        if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      end
    end
  end

  typedef struct { logic [3:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] dir; logic [4:0] steps; logic [15:0] intv; logic err; int nwr; } vec_t;

  wr_t  exp_q[$];
  int   spacings[$];
  int   nchk = 0, nfail = 0;
  int   cyc = 0, last_rise = -1, data_writes = 0, done_cnt = 0, b_cnt = 0;
  int   split_cnt = 0, aw_rise_cnt = 0;
  logic aw_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int i, input int k);
    return 32'((i << 8) | (k + 1));
  endfunction

  // Scoreboard/monitor, sampled mid-cycle.
  initial forever begin
    @(negedge aclk);
    cyc++;
    if (!areset && pair) begin
      if (exp_q.size() == 0) chk("unexpected_write", {28'd0, a_n, d_n}, 64'hFFFF_FFFF);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(a_n), 64'(e.addr));
        chk("write_data", 64'(d_n), 64'(e.data));
      end
      if (a_n == 4'h0) data_writes++;
    end
    if (m_axi_awvalid && !aw_prev) begin
      aw_rise_cnt++;
      if (m_axi_awaddr == 4'h0) begin
        if (last_rise >= 0) spacings.push_back(cyc - last_rise);
        last_rise = cyc;
      end
    end
    aw_prev = m_axi_awvalid;
    if (m_axi_bvalid && m_axi_bready) b_cnt++;
    if (!m_axi_awvalid && m_axi_wvalid) split_cnt++;
    if (done) done_cnt++;
  end

  task automatic clear_counts();
    spacings.delete();
    last_rise = -1; data_writes = 0; done_cnt = 0; b_cnt = 0; split_cnt = 0; aw_rise_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("error_cleared_on_start", 64'(error), 64'd0);
    chk("awvalid_t1", 64'(m_axi_awvalid), 64'd0);
    @(posedge aclk); #1;
    chk("awvalid_t2", 64'(m_axi_awvalid), 64'd1);
  endtask

  task automatic wait_done(output int gap);
    int t;
    gap = 0;
    for (t = 0; t < 3000; t++) begin
      if (done) break;
      if (!busy) gap++;
      @(posedge aclk); #1;
    end
    if (t == 3000) chk("done_timeout", 64'd0, 64'd1);
    else chk("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  task automatic wait_writes(input int n);
    int t;
    for (t = 0; t < 2000 && data_writes < n; t++) begin
      @(posedge aclk); #1;
    end
    if (t == 2000) chk("write_wait_timeout", 64'd0, 64'd1);
  endtask

  vec_t vecs[6];
  logic [31:0] exp_gpio;
  int gap;

  initial begin
    vecs[0] = '{32'hFF, 5'd3,  16'd0, 1'b0, 3};
    vecs[1] = '{32'h0F, 5'd2,  16'd5, 1'b0, 2};
    vecs[2] = '{32'h00, 5'd0,  16'd0, 1'b0, 0};
    vecs[3] = '{32'hAA, 5'd20, 16'd1, 1'b0, 8};
    vecs[4] = '{32'h55, 5'd4,  16'd0, 1'b1, 1};
    vecs[5] = '{32'h3C, 5'd1,  16'd2, 1'b0, 1};

    areset = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    dir_mask = '0; pattern = '0; num_steps = '0; interval = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", {20'd0, busy, done, error, step_idx, m_axi_awvalid, m_axi_wvalid,
                          m_axi_bready, m_axi_awaddr, m_axi_wdata}, 64'd0);
    areset = 1'b0;
    @(posedge aclk); #1;
    exp_gpio = '0;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < DEPTH; k++) pattern[32*k +: 32] = ent(i, k);
      dir_mask = vecs[i].dir; num_steps = vecs[i].steps; interval = vecs[i].intv;
      err_req = vecs[i].err;
      exp_q.push_back('{4'h4, vecs[i].dir});
      for (int k = 0; k < vecs[i].nwr; k++) exp_q.push_back('{4'h0, ent(i, k)});
      if (vecs[i].nwr > 0) exp_gpio = ent(i, vecs[i].nwr - 1);
      clear_counts();
      do_start();
      wait_done(gap);
      chk("busy_gap", 64'(gap), 64'd0);
      chk("final_error", 64'(error), 64'(vecs[i].err));
      chk("final_step_idx", 64'(step_idx), (vecs[i].nwr > 0) ? 64'(vecs[i].nwr - 1) : 64'd0);
      repeat (4) @(posedge aclk);
      #1;
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
      chk("gpio_out", 64'(gpio_out), 64'(exp_gpio));
      chk("gpio_dir", 64'(gpio_dir), 64'(vecs[i].dir));
      foreach (spacings[j]) chk("data_spacing", 64'(spacings[j]), 64'(4 + vecs[i].intv));
      exp_q.delete();
    end
    err_req = 1'b0;

    // Delayed wready: address handshakes first, wdata held, one B per write.
    wdly_req = 1'b1; num_steps = 5'd1; interval = '0;
    exp_q.push_back('{4'h4, dir_mask});
    exp_q.push_back('{4'h0, pattern[31:0]});
    clear_counts();
    do_start();
    wait_done(gap);
    repeat (2) @(posedge aclk);
    #1;
    chk("b_count", 64'(b_cnt), 64'd2);
    chk("aw_drop_w_held", 64'(split_cnt > 0), 64'd1);
    chk("wdly_outstanding", 64'(exp_q.size()), 64'd0);
    wdly_req = 1'b0; exp_q.delete();

    // Looping playback aborted during DELAY.
    loop_en = 1'b1; num_steps = 5'd2; interval = 16'd10;
    exp_q.push_back('{4'h4, dir_mask});
    for (int k = 0; k < 20; k++) exp_q.push_back('{4'h0, pattern[32*(k%2) +: 32]});
    clear_counts();
    do_start();
    wait_writes(4);
    repeat (3) @(posedge aclk);
    #1;
    abort = 1'b1;
    @(posedge aclk); #1;
    abort = 1'b0;
    chk("abort_done", 64'(done), 64'd1);
    chk("abort_step_idx", 64'(step_idx), 64'd1);
    aw_rise_cnt = 0;
    repeat (15) @(posedge aclk);
    #1;
    chk("no_aw_after_abort", 64'(aw_rise_cnt), 64'd0);
    chk("abort_done_pulses", 64'(done_cnt), 64'd1);
    loop_en = 1'b0; exp_q.delete();

    // Reset in the middle of DELAY.
    num_steps = 5'd2; interval = 16'd20;
    exp_q.push_back('{4'h4, dir_mask});
    exp_q.push_back('{4'h0, pattern[31:0]});
    exp_q.push_back('{4'h0, pattern[63:32]});
    clear_counts();
    do_start();
    wait_writes(1);
    repeat (4) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("reset_mid_delay", {20'd0, busy, done, error, step_idx, m_axi_awvalid, m_axi_wvalid,
                            m_axi_bready, m_axi_awaddr, m_axi_wdata}, 64'd0);
    areset = 1'b0; exp_q.delete();
    repeat (2) @(posedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
